reg_to_obi: RTL
===============

REG_TO_OBI -- requirements
Module: reg_to_obi

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the max cycles waiting for gnt before error completion; 0 disables the timeout.
REQ-002 SHALL have parameter TW, default 8, meaning the timeout counter width; TIMEOUT_CYCLES SHALL fit in TW bits.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port reg_req_i, input, reg_pkg::reg_req_t (valid, write, addr[31:0], wdata[31:0], wstrb[3:0]), the register-port request from the upstream initiator.
REQ-006 SHALL have port reg_rsp_o, output, reg_pkg::reg_rsp_t (ready, rdata[31:0], error), the register-port response.
REQ-007 SHALL have port obi_req_o, output, obi_pkg::obi_req_t (req, we, be[3:0], addr[31:0], wdata[31:0]), the OBI master request into the system crossbar.
REQ-008 SHALL have port obi_resp_i, input, obi_pkg::obi_resp_t (gnt, rvalid, rdata[31:0]), the OBI response.

Function
REQ-009 SHALL implement FSM states IDLE, REQ, RESP, DONE; all outputs registered.
REQ-010 IDLE: on reg_req_i.valid=1, capture addr (bits[1:0] forced 0), wdata, wstrb->be, write->we; clear timeout counter; go to REQ.
REQ-011 REQ: obi_req_o.req=1 with addr/we/be/wdata held constant from the captured values until gnt is sampled.
REQ-012 REQ with obi_resp_i.gnt=1: drop req on the next edge; go to RESP.
REQ-013 RESP: wait for obi_resp_i.rvalid; rvalid in the same cycle as gnt (in REQ) SHALL be ignored, per OBI.
REQ-014 RESP with rvalid=1: capture rdata into reg_rsp_o.rdata; set error=0; go to DONE.
REQ-015 DONE: reg_rsp_o.ready=1 for exactly one cycle; next state IDLE; ready=0 in all other states.
REQ-016 reg_rsp_o.rdata and error SHALL hold their last values until the next completion.
REQ-017 rdata SHALL be returned for writes as well, with the value the slave drives.
REQ-018 Minimum latency, with valid at edge N, gnt at N+1 and rvalid at N+2: req high from N+1, ready high at N+3.
REQ-019 Timeout: the counter SHALL increment each cycle in REQ without gnt, saturating.
REQ-020 On timeout, when the count reaches TIMEOUT_CYCLES with TIMEOUT_CYCLES!=0: drop req; set rdata=32'h0 and error=1; go to DONE.
REQ-021 gnt sampled in the same cycle the count reaches TIMEOUT_CYCLES: gnt wins, no error.
REQ-022 The RESP state SHALL have no timeout.
REQ-023 In DONE, the transaction SHALL NOT restart even if reg_req_i.valid is still 1; a new capture is possible only from IDLE, the cycle after DONE, so back-to-back throughput is one transaction per 4 cycles minimum.
REQ-024 Dropping reg_req_i.valid or changing its fields after capture SHALL NOT affect the in-flight transaction, which completes with a ready pulse.
REQ-025 Spurious gnt or rvalid in IDLE/DONE SHALL be ignored.
REQ-026 At most one OBI transaction SHALL be outstanding at any time.

Reset
REQ-027 With rst_i=1 at an edge, the FSM SHALL enter IDLE, regardless of current state.
REQ-028 Reset values: obi_req_o.req=0, we=0, be=0, addr=0, wdata=0; reg_rsp_o.ready=0, rdata=0, error=0; counter=0.
REQ-029 Reset mid-transaction SHALL drop req on that edge and SHALL produce no ready pulse for the aborted transaction.

Verification
REQ-030 Read: valid, write=0, addr=0x0000_1006; gnt and rvalid each one cycle later, rdata=0xDEADBEEF -> OBI addr=0x0000_1004, we=0; one-cycle ready with rdata=0xDEADBEEF and error=0 at N+3.
REQ-031 Write with gnt stalled 5 cycles: wdata=0x12345678, wstrb=4'b0101 -> req held 6 cycles with stable be=4'b0101 and we=1; single ready pulse after rvalid.
REQ-032 Timeout with TIMEOUT_CYCLES=4, gnt never asserted -> req high for exactly 4 cycles, then dropped; ready with error=1, rdata=0.
REQ-033 Same-cycle rvalid+gnt, followed by rvalid with rdata=0xA5A5A5A5 on the next cycle -> the first rvalid is ignored; reg rdata=0xA5A5A5A5.
REQ-034 rst_i asserted in RESP state -> all outputs at reset values next edge, no ready pulse, and a new request is accepted normally afterwards.
REQ-035 reg_req_i.valid held high across two transactions -> two distinct OBI transactions, two ready pulses, spaced at least 4 cycles apart.

Source files
------------

// File: rtl/obi_pkg.sv
// OBI master request/response types for the system crossbar.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/reg_pkg.sv
// Register-port request/response types shared by upstream initiators.
package reg_pkg;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } reg_req_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] rdata;
    logic        error;
  } reg_rsp_t;

endpackage

// File: rtl/reg_to_obi.sv
// Bridges a single-outstanding register port onto an OBI master, with an
// optional grant timeout that completes the access with an error.
//
// state | meaning
// IDLE  | waiting for reg_req_i.valid; captures the request
// REQ   | OBI req held; waiting for gnt or timeout
// RESP  | grant taken; waiting for rvalid (no timeout here)
// DONE  | reg_rsp_o.ready pulsed for this one cycle
module reg_to_obi #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TW             = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  reg_pkg::reg_req_t   reg_req_i,
  output reg_pkg::reg_rsp_t   reg_rsp_o,
  output obi_pkg::obi_req_t   obi_req_o,
  input  obi_pkg::obi_resp_t  obi_resp_i
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  localparam bit            TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] CNT_MAX  = {TW{1'b1}};

  state_t             state_q, state_d;
  logic [TW-1:0]      cnt_q, cnt_d;
  obi_pkg::obi_req_t  obi_q, obi_d;
  reg_pkg::reg_rsp_t  rsp_q, rsp_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      obi_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      obi_q   <= obi_d;
      rsp_q   <= rsp_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    obi_d         = obi_q;
    rsp_d         = rsp_q;
    rsp_d.ready   = 1'b0;
    case (state_q)
      IDLE: begin
        if (reg_req_i.valid) begin
          obi_d.req   = 1'b1;
          obi_d.we    = reg_req_i.write;
          obi_d.be    = reg_req_i.wstrb;
          obi_d.addr  = reg_req_i.addr & 32'hFFFF_FFFC;
          obi_d.wdata = reg_req_i.wdata;
          cnt_d       = '0;
          state_d     = REQ;
        end
      end
      REQ: begin
        // A grant in the same cycle the count expires still wins.
        if (obi_resp_i.gnt) begin
          obi_d.req = 1'b0;
          state_d   = RESP;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          obi_d.req   = 1'b0;
          rsp_d.rdata = 32'h0;
          rsp_d.error = 1'b1;
          rsp_d.ready = 1'b1;
          state_d     = DONE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (obi_resp_i.rvalid) begin
          rsp_d.rdata = obi_resp_i.rdata;
          rsp_d.error = 1'b0;
          rsp_d.ready = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign obi_req_o = obi_q;
  assign reg_rsp_o = rsp_q;

endmodule
